// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, talks to instruction
// memory over a req/ack handshake, applies branch/writeback redirects and
// drives the F/D pipeline register. A one-entry hold buffer keeps a word
// that arrives while decode is stalled.
//
// Memory handshake: imem_req is a request-valid and imem_ack a response-valid.
// A request is accepted on the first rising edge where imem_req and imem_ack
// are both high. imem_addr is stable from the first cycle of imem_req until
// that edge. imem_rdata is only meaningful while imem_ack is high. Neither
// imem_req nor imem_addr depends combinationally on imem_ack.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drop_q;
  logic [31:0] buf_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        load_en;
  logic [31:0] load_word;

  // The execute-stage branch beats a writeback PC write; targets are word aligned.
  assign redirect = BranchTakenE | PCSrcW;
  assign target   = (BranchTakenE ? BranchTargetE : ResultW) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // Request is driven only from registered state; silenced while reset is held.
  assign imem_req  = reset & ((state_q == S_FETCH) | (state_q == S_DISCARD));
  assign imem_addr = (state_q == S_DISCARD) ? drop_q : pc_q;
  assign fsm_state = state_q;

  // Select the word (if any) that is ready to enter the F/D register this cycle.
  always_comb begin
    load_en   = 1'b0;
    load_word = buf_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack && !redirect) begin
          load_en   = 1'b1;
          load_word = imem_rdata;
        end
      end
      S_HOLD: begin
        if (!redirect) begin
          load_en   = 1'b1;
          load_word = buf_q;
        end
      end
      default: begin
        load_en   = 1'b0;
        load_word = buf_q;
      end
    endcase
  end

  // Fetch FSM, PC/drop/hold registers and the F/D pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_q      <= 32'h0000_0000;
      buf_q       <= NOP;
      Instruction <= NOP;
      PCPlus8D    <= 32'h0000_0000;
      ValidD      <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (redirect) begin
            pc_q <= target;
            if (!imem_ack) begin
              // Request still outstanding: remember it so it can be drained.
              drop_q  <= pc_q;
              state_q <= S_DISCARD;
            end
          end else if (imem_ack) begin
            if (StallD) begin
              buf_q   <= imem_rdata;
              state_q <= S_HOLD;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= S_FETCH;
          end else if (!StallD) begin
            pc_q    <= pc_plus4;
            state_q <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem_ack) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase

      // Stall freezes F/D; flush or no ready word inserts a bubble.
      if (!StallD) begin
        if (load_en && !FlushD) begin
          Instruction <= load_word;
          PCPlus8D    <= pc_plus8;
          ValidD      <= 1'b1;
        end else begin
          Instruction <= NOP;
          ValidD      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a word-returns-address
// instruction memory of configurable wait count and a scoreboard of expected
// F/D loads.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PCPlus8D;
  logic        ValidD;
  logic [1:0]  fsm_state;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          mem_wait = 0;
  int          mem_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        stall_at_edge;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no end, required end");
    $fatal(1);
  end

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .Instruction   (Instruction),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD),
    .fsm_state     (fsm_state)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_req(input logic r, input logic [31:0] a);
    #1;
    chk("imem_req", 32'(imem_req), 32'(r));
    if (r) chk("imem_addr", imem_addr, a);
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: memory answers the current request, then redirect and
  // flush pulses are cleared at the following falling edge.
  task automatic step();
    logic req_s;
    logic ack_s;
    #1;
    req_s      = imem_req;
    ack_s      = req_s && (mem_cnt >= mem_wait);
    imem_ack   = ack_s;
    imem_rdata = ack_s ? imem_addr : 32'hDEAD_BEEF;
    @(posedge clk);
    if (ack_s) mem_cnt = 0;
    else if (req_s) mem_cnt++;
    @(negedge clk);
    imem_ack     = 1'b0;
    BranchTakenE = 1'b0;
    PCSrcW       = 1'b0;
    FlushD       = 1'b0;
  endtask

  // Zero-wait fetch of address a that must land in F/D.
  task automatic fetch_ok(input logic [31:0] a);
    chk_req(1'b1, a);
    exp_q.push_back({a, a + 32'd8});
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  // A new F/D load is visible just after an edge where decode was not stalled.
  always @(posedge clk) begin
    stall_at_edge = StallD;
    #1;
    if (reset && !stall_at_edge && ValidD) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL fd_unexpected: got %h/%h, expected no valid load (t=%0t)",
                 Instruction, PCPlus8D, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({Instruction, PCPlus8D} !== mon_exp) begin
          n_mis++;
          $display("FAIL fd_load: got %h/%h, expected %h/%h (t=%0t)",
                   Instruction, PCPlus8D, mon_exp[63:32], mon_exp[31:0], $time);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; BranchTargetE = 32'h0;
    PCSrcW = 1'b0; ResultW = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #3 reset = 1'b0;

    // Reset values
    @(negedge clk); #1;
    chk("rst_instr", Instruction, NOP);
    chk("rst_pc8",   PCPlus8D, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait streaming: 0x0, 0x4, 0x8, 0xC
    for (int i = 0; i < 4; i++) fetch_ok(32'(i * 4));

    // Stall three cycles while the 0x10 ack arrives
    StallD = 1'b1;
    chk_req(1'b1, 32'h10);
    step();
    chk("stall_state", 32'(fsm_state), 32'h1);
    chk("stall_instr", Instruction, 32'hC);
    chk("stall_valid", 32'(ValidD), 32'h1);
    for (int i = 0; i < 2; i++) begin
      chk_req(1'b0, 32'h10);
      step();
      chk("stall_hold", Instruction, 32'hC);
    end
    StallD = 1'b0;
    chk_req(1'b0, 32'h10);
    exp_q.push_back({32'h10, 32'h18});
    step();

    // Two wait cycles per word: ValidD 0,0,1 with PCPlus8D held on bubbles
    mem_wait = 2;
    for (int r = 0; r < 2; r++) begin
      logic [31:0] a;
      a = 32'h14 + 32'(r * 4);
      chk_req(1'b1, a);
      step();
      chk("wait_valid0", 32'(ValidD), 32'h0);
      chk("wait_pc8",    PCPlus8D, a + 32'd4);
      chk_req(1'b1, a);
      step();
      chk("wait_valid1", 32'(ValidD), 32'h0);
      chk_req(1'b1, a);
      exp_q.push_back({a, a + 32'd8});
      step();
    end
    mem_wait = 0;
    fetch_ok(32'h1C);

    // Branch to 0x100 while 0x20 is outstanding with two waits
    mem_wait = 2;
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    chk_req(1'b1, 32'h20);
    step();
    chk("br_valid0", 32'(ValidD), 32'h0);
    chk("br_state",  32'(fsm_state), 32'h2);
    chk_req(1'b1, 32'h20);
    step();
    chk("br_valid1", 32'(ValidD), 32'h0);
    chk_req(1'b1, 32'h20);
    step();
    chk("br_drop", 32'(ValidD), 32'h0);
    mem_wait = 0;
    fetch_ok(32'h100);

    // Branch and writeback redirect together: branch wins
    BranchTakenE = 1'b1; BranchTargetE = 32'h200;
    PCSrcW = 1'b1; ResultW = 32'h300;
    chk_req(1'b1, 32'h104);
    step();
    chk("both_valid", 32'(ValidD), 32'h0);
    fetch_ok(32'h200);

    // Writeback redirect with unaligned value 0x43 lands on 0x40
    PCSrcW = 1'b1; ResultW = 32'h43;
    chk_req(1'b1, 32'h204);
    step();

    // Flush in the cycle 0x40 is acked
    FlushD = 1'b1;
    chk_req(1'b1, 32'h40);
    step();
    chk("flush_instr", Instruction, NOP);
    chk("flush_valid", 32'(ValidD), 32'h0);
    chk("flush_pc8",   PCPlus8D, 32'h208);
    fetch_ok(32'h44);

    // PC wrap at the top of the address space
    PCSrcW = 1'b1; ResultW = 32'hFFFF_FFFC;
    chk_req(1'b1, 32'h48);
    step();
    chk_req(1'b1, 32'hFFFF_FFFC);
    exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0004});
    step();

    // Reset asserted while holding the word from address 0x0
    StallD = 1'b1;
    chk_req(1'b1, 32'h0);
    step();
    chk("hold_before_rst", 32'(fsm_state), 32'h1);
    reset = 1'b0; StallD = 1'b0; mem_cnt = 0;
    #1;
    chk("rst_hold_valid", 32'(ValidD), 32'h0);
    chk("rst_hold_req",   32'(imem_req), 32'h0);
    chk("rst_hold_instr", Instruction, NOP);
    chk("rst_hold_state", 32'(fsm_state), 32'h0);
    step();
    reset = 1'b1;
    fetch_ok(32'h0);

    // Redirect while holding: buffered word 0x4 is discarded
    StallD = 1'b1;
    chk_req(1'b1, 32'h4);
    step();
    StallD = 1'b0; BranchTakenE = 1'b1; BranchTargetE = 32'h80;
    chk_req(1'b0, 32'h4);
    step();
    chk("hold_redir_valid", 32'(ValidD), 32'h0);
    fetch_ok(32'h80);

    // Redirect during a discard: the later redirect wins
    mem_wait = 1;
    BranchTakenE = 1'b1; BranchTargetE = 32'h500;
    chk_req(1'b1, 32'h84);
    step();
    PCSrcW = 1'b1; ResultW = 32'h600;
    chk_req(1'b1, 32'h84);
    step();
    chk("disc_redir_valid", 32'(ValidD), 32'h0);
    mem_wait = 0;
    fetch_ok(32'h600);

    // ---------------- final report ----------------
    chk("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
